// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: PC/instruction-memory port, decode handshake, redirect and fault reporting.
// The fetch unit takes the master side; decode and memory take the slave side.
interface instr_fetch_if;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;
  logic [15:0] fetch_count;

  modport master (
    input  fetch_en, imem_rd, instr_ready, redirect, redirect_pc,
    output imem_addr, instr, instr_pc, pc_plus4, instr_valid, fault, fault_pc, fetch_count
  );

  modport slave (
    output fetch_en, imem_rd, instr_ready, redirect, redirect_pc,
    input  imem_addr, instr, instr_pc, pc_plus4, instr_valid, fault, fault_pc, fetch_count
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage of the multi-cycle RISC-V core: owns the PC and captures the instruction word
// for decode. A redirect always wins over the current state.
//
// state | meaning
// IDLE  | waiting for fetch_en
// FETCH | PC on imem_addr; capture imem_rd, or fault on a bad address
// HOLD  | instr valid, waiting for decode to take it
// FAULT | bad fetch address reported; frozen until redirect
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 128
) (
  input logic           clk,
  input logic           resetn,
  instr_fetch_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [15:0] count_q, count_d;
  logic        handshake;
  logic        bad_pc;

  assign handshake = valid_q && bus.instr_ready;
  assign bad_pc    = (pc_q[1:0] != 2'b00) || (pc_q >= IMEM_DEPTH);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    // A handshake completing on a redirect edge still counts.
    count_d    = handshake ? count_q + 16'd1 : count_q;

    if (bus.redirect) begin
      pc_d    = bus.redirect_pc;
      fault_d = 1'b0;
      valid_d = 1'b0;
      state_d = bus.fetch_en ? ST_FETCH : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.fetch_en) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (bad_pc) begin
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
            state_d    = ST_FAULT;
          end else begin
            instr_d    = bus.imem_rd;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
            valid_d    = 1'b1;
            state_d    = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.instr_ready) begin
            valid_d = 1'b0;
            state_d = bus.fetch_en ? ST_FETCH : ST_IDLE;
          end
        end
        ST_FAULT: begin
          valid_d = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'd0;
      count_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.pc_plus4    = instr_pc_q + 32'd4;
  assign bus.instr_valid = valid_q;
  assign bus.fault       = fault_q;
  assign bus.fault_pc    = fault_pc_q;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: expected (instr, pc) pairs are queued as stimulus is applied
// and popped when decode completes a handshake.
module tb_instr_fetch;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic [31:0] mem [32];
  exp_t        sb [$];
  int          vectors;
  int          errors;
  int          exp_cnt;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(32'h0000_0000), .IMEM_DEPTH(128)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.imem_rd = (bus.imem_addr < 32'd128) ? mem[bus.imem_addr[6:2]] : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are set just after a negedge; a handshake seen now completes on the coming posedge.
  task automatic step();
    exp_t e;
    if (bus.instr_valid && bus.instr_ready) begin
      vectors++;
      assert (sb.size() != 0)
      else begin
        errors++;
        $error("FAIL unexpected_handshake observed=%h expected=none", bus.instr_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("instr", bus.instr, e.word);
        chk("instr_pc", bus.instr_pc, e.pc);
        chk("pc_plus4", bus.pc_plus4, e.pc + 32'd4);
        exp_cnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_until_empty(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
    step();
  endtask

  initial begin
    int n;
    vectors = 0;
    errors  = 0;
    exp_cnt = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h0010_0093;
    mem[1] = 32'h0010_0113;
    mem[2] = 32'h0020_8063;

    resetn          = 1'b0;
    bus.fetch_en    = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    #2;
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_instr_pc", bus.instr_pc, 0);
    chk("rst_pc_plus4", bus.pc_plus4, 32'd4);
    chk("rst_fault", bus.fault, 0);
    chk("rst_fault_pc", bus.fault_pc, 0);
    chk("rst_count", bus.fetch_count, 0);

    // Sequential fetch with ready tied high
    @(negedge clk);
    resetn          = 1'b1;
    bus.fetch_en    = 1'b1;
    bus.instr_ready = 1'b1;
    sb.push_back('{32'h0010_0093, 32'h0});
    sb.push_back('{32'h0010_0113, 32'h4});
    sb.push_back('{32'h0020_8063, 32'h8});
    step();
    chk("lat_fetch_cycle", bus.instr_valid, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("valid_alternate", bus.instr_valid, (i % 2 == 0) ? 32'd1 : 32'd0);
      step();
    end
    chk("seq_count", bus.fetch_count, 32'd3);
    chk("seq_drained", sb.size(), 0);

    // Backpressure on the word at pc 4
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h4;
    bus.instr_ready = 1'b0;
    step();
    bus.redirect = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", bus.instr_valid, 1);
      chk("bp_instr", bus.instr, 32'h0010_0113);
      chk("bp_instr_pc", bus.instr_pc, 32'h4);
      chk("bp_addr", bus.imem_addr, 32'h8);
      chk("bp_count", bus.fetch_count, 32'd3);
      step();
    end
    sb.push_back('{32'h0010_0113, 32'h4});
    bus.instr_ready = 1'b1;
    step();
    chk("bp_count_after", bus.fetch_count, 32'd4);

    // Redirect drops the held word at pc 8
    bus.instr_ready = 1'b0;
    step();
    chk("hold8_pc", bus.instr_pc, 32'h8);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0;
    step();
    bus.redirect = 1'b0;
    chk("drop_valid", bus.instr_valid, 0);
    chk("drop_count", bus.fetch_count, 32'd4);
    chk("drop_addr", bus.imem_addr, 32'h0);
    bus.instr_ready = 1'b1;
    sb.push_back('{32'h0010_0093, 32'h0});
    run_until_empty(10);
    chk("drop_count_after", bus.fetch_count, exp_cnt);

    // Redirect and handshake on the same edge
    bus.instr_ready = 1'b0;
    step();
    chk("rh_valid", bus.instr_valid, 1);
    sb.push_back('{32'h0010_0113, 32'h4});
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    bus.instr_ready = 1'b1;
    step();
    chk("rh_count", bus.fetch_count, 32'd6);
    chk("rh_addr", bus.imem_addr, 32'h40);
    chk("rh_valid_after", bus.instr_valid, 0);

    // Misaligned redirect target faults at the following FETCH
    bus.redirect_pc = 32'h6;
    step();
    bus.redirect = 1'b0;
    chk("mis_addr", bus.imem_addr, 32'h6);
    chk("mis_no_fault_yet", bus.fault, 0);
    step();
    chk("mis_fault", bus.fault, 1);
    chk("mis_fault_pc", bus.fault_pc, 32'h6);
    chk("mis_valid", bus.instr_valid, 0);
    step();
    step();
    chk("mis_sticky", bus.fault, 1);
    chk("mis_pc_frozen", bus.imem_addr, 32'h6);

    // Sequential run off the end of memory
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h74;
    step();
    bus.redirect = 1'b0;
    chk("oor_fault_cleared", bus.fault, 0);
    sb.push_back('{mem[29], 32'h74});
    sb.push_back('{mem[30], 32'h78});
    sb.push_back('{mem[31], 32'h7C});
    n = 0;
    while (bus.fault !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("oor_fault", bus.fault, 1);
    chk("oor_fault_pc", bus.fault_pc, 32'h80);
    chk("oor_addr", bus.imem_addr, 32'h80);
    chk("oor_valid", bus.instr_valid, 0);
    chk("oor_drained", sb.size(), 0);
    chk("oor_count", bus.fetch_count, 32'd9);

    // Recovery by redirect to 0
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0;
    step();
    bus.redirect = 1'b0;
    chk("rec_fault", bus.fault, 0);
    chk("rec_addr", bus.imem_addr, 32'h0);
    sb.push_back('{32'h0010_0093, 32'h0});
    run_until_empty(10);
    chk("rec_count", bus.fetch_count, exp_cnt);

    // Asynchronous reset while holding
    bus.instr_ready = 1'b0;
    step();
    chk("pre_rst_valid", bus.instr_valid, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_valid", bus.instr_valid, 0);
    chk("arst_addr", bus.imem_addr, 32'h0);
    chk("arst_count", bus.fetch_count, 0);
    chk("arst_instr_pc", bus.instr_pc, 0);
    @(negedge clk);
    resetn          = 1'b1;
    exp_cnt         = 0;
    bus.instr_ready = 1'b1;
    sb.push_back('{32'h0010_0093, 32'h0});
    run_until_empty(10);
    chk("post_rst_count", bus.fetch_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
